bcd_counter_mux7seg: RTL and testbench

BCD_COUNTER_MUX7SEG -- requirements
Module: bcd_counter_mux7seg

---
 rtl/bcd_counter_mux7seg.sv | 174 +++++++++++++++++
 tb/tb_bcd_counter_mux7seg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_mux7seg.sv
// Multi-digit BCD up/down counter with a multiplexed active-low 7-segment driver.
// Ports: clk, rst (sync, active-high), en, up, load, load_val[4*DIGITS] in;
//        count[4*DIGITS], carry, seg[6:0] {a..g}, an[DIGITS] out.
// Optional macro BLANK_LEADING_ZERO_EN blanks digits above the top nonzero digit.
module bcd_counter_mux7seg #(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 24,
  parameter int SCAN_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick;
  logic                wrap;
  logic [4*DIGITS-1:0] step_v;
  logic [4*DIGITS-1:0] load_v;
  logic [DIGITS-1:0]   blank_v;
  logic [3:0]          cur;
  logic                cur_blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign tick   = &div_q;
  assign div_d  = div_q + 1'b1;
  assign scan_d = scan_q + 1'b1;

  // Decimal step with ripple; rip surviving every digit means a wrap.
  always_comb begin
    logic       rip;
    logic [3:0] dig;
    step_v = cnt_q;
    rip    = 1'b1;
    dig    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = cnt_q[4*i +: 4];
      if (rip) begin
        if (up) begin
          if (dig == 4'd9) begin
            step_v[4*i +: 4] = 4'd0;
          end else begin
            step_v[4*i +: 4] = dig + 4'd1;
            rip = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            step_v[4*i +: 4] = 4'd9;
          end else begin
            step_v[4*i +: 4] = dig - 4'd1;
            rip = 1'b0;
          end
        end
      end
    end
    wrap = rip;
  end

  // Non-BCD load digits are forced to zero.
  always_comb begin
    load_v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_v[4*i +: 4] = 4'd0;
      else                           load_v[4*i +: 4] = load_val[4*i +: 4];
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    if (load) begin
      cnt_d = load_v;
    end else if (tick && en) begin
      cnt_d   = step_v;
      carry_d = wrap;
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (&scan_q) begin
      if (idx_q == IDX_W'(DIGITS - 1)) idx_d = '0;
      else                             idx_d = idx_q + 1'b1;
    end
  end

`ifdef BLANK_LEADING_ZERO_EN
  // A digit blanks when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    logic zero_above;
    blank_v    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (cnt_q[4*i +: 4] == 4'd0);
      blank_v[i] = zero_above;
    end
  end
`else
  assign blank_v = '0;
`endif

  always_comb begin
    cur       = '0;
    cur_blank = 1'b0;
    an_d      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur       = cnt_q[4*i +: 4];
        cur_blank = blank_v[i];
        an_d[i]   = 1'b0;
      end
    end
    seg_d = cur_blank ? 7'b1111111 : seg7(cur);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      seg_q   <= 7'b1111111;
      an_q    <= '1;
    end else begin
      div_q   <= div_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign count = cnt_q;
  assign carry = carry_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_bcd_counter_mux7seg.sv
// Directed scoreboard bench for bcd_counter_mux7seg (DIGITS=4, DIV_W=2, SCAN_W=1).
module tb_bcd_counter_mux7seg;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        carry;
  logic [6:0]  seg;
  logic [3:0]  an;

  logic [1:0]  mdiv;
  logic [15:0] sbq[$];
  int          tests;
  int          fails;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] SB = 7'b1111111;

  bcd_counter_mux7seg #(
    .DIGITS(4),
    .DIV_W (2),
    .SCAN_W(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .carry   (carry),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  // Reference divider: tick is the cycle where it reads 3.
  always @(posedge clk) begin
    if (rst) mdiv <= 2'd0;
    else     mdiv <= mdiv + 2'd1;
  end

  task automatic push(input logic [15:0] v);
    sbq.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    tests++;
    if (sbq.size() == 0) begin
      exp = 16'hxxxx;
    end else begin
      exp = sbq.pop_front();
    end
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a tick cycle, then let the stepping edge pass.
  task automatic step_edge(input string tag);
    int n;
    n = 0;
    while (mdiv != 2'd3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    assert (mdiv == 2'd3) else begin
      fails++;
      $error("FAIL %s: tick wait timed out, div %0d expected 3", tag, mdiv);
    end
    @(negedge clk);
  endtask

  // Bounded wait for the first cycle in which digit 0 is selected.
  task automatic scan_sync(input string tag);
    int n;
    n = 0;
    while (an !== 4'b0111 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (an === 4'b0111 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    assert (an === 4'b1110) else begin
      fails++;
      $error("FAIL %s: scan sync an %b expected 1110", tag, an);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    logic [3:0] an_e[4];
    logic [6:0] sg_e[4];
    clk      = 1'b0;
    rst      = 1'b1;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;
    tests    = 0;
    fails    = 0;
    an_e[0] = 4'b1110;
    an_e[1] = 4'b1101;
    an_e[2] = 4'b1011;
    an_e[3] = 4'b0111;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push(16'h0000); check("rst_count", count);
    push(16'h0000); check("rst_carry", 16'(carry));
    push(16'h000F); check("rst_an", 16'(an));
    push(16'h007F); check("rst_seg", 16'(seg));
    @(negedge clk);
    push(16'h000E); check("first_an", 16'(an));
    push(16'(S0));  check("first_seg", 16'(seg));

    en = 1'b1;
    up = 1'b1;
    do_load(16'h9999);
    push(16'h9999); check("up_load", count);
    step_edge("up_tick");
    push(16'h0000); check("up_wrap_count", count);
    push(16'h0001); check("up_wrap_carry", 16'(carry));
    @(negedge clk);
    push(16'h0000); check("up_carry_off", 16'(carry));

    up = 1'b0;
    do_load(16'h1000);
    step_edge("dn_tick1");
    push(16'h0999); check("dn_ripple", count);
    push(16'h0000); check("dn_ripple_carry", 16'(carry));
    do_load(16'h0000);
    push(16'h0000); check("dn_load0", count);
    push(16'h0000); check("load_no_carry", 16'(carry));
    step_edge("dn_tick2");
    push(16'h9999); check("dn_wrap_count", count);
    push(16'h0001); check("dn_wrap_carry", 16'(carry));
    @(negedge clk);
    push(16'h0000); check("dn_carry_off", 16'(carry));

    // Load lands on a tick with en=1; a step from 9999 would wrap.
    up = 1'b1;
    do_load(16'h9999);
    while (mdiv != 2'd3) @(negedge clk);
    do_load(16'h3A7F);
    en = 1'b0;
    push(16'h3070); check("ld_prio_count", count);
    push(16'h0000); check("ld_prio_carry", 16'(carry));
    @(negedge clk);
    push(16'h0000); check("ld_prio_carry2", 16'(carry));
    push(16'h3070); check("ld_prio_hold", count);

    do_load(16'h1234);
    sg_e[0] = S4; sg_e[1] = S3; sg_e[2] = S2; sg_e[3] = S1;
    scan_sync("scan1234");
    for (int k = 0; k < 8; k++) begin
      push(16'(an_e[k/2]));
      push(16'(sg_e[k/2]));
    end
    for (int k = 0; k < 8; k++) begin
      check("scan_an", 16'(an));
      check("scan_seg", 16'(seg));
      @(negedge clk);
    end

`ifdef BLANK_LEADING_ZERO_EN
    sg_e[0] = S5; sg_e[1] = SB; sg_e[2] = SB; sg_e[3] = SB;
`else
    sg_e[0] = S5; sg_e[1] = S0; sg_e[2] = S0; sg_e[3] = S0;
`endif
    do_load(16'h0005);
    scan_sync("scan0005");
    for (int k = 0; k < 4; k++) begin
      push(16'(an_e[k]));
      push(16'(sg_e[k]));
      check("s5_an", 16'(an));
      check("s5_seg", 16'(seg));
      repeat (2) @(negedge clk);
    end

`ifdef BLANK_LEADING_ZERO_EN
    sg_e[0] = S0; sg_e[1] = SB; sg_e[2] = SB; sg_e[3] = SB;
`else
    sg_e[0] = S0; sg_e[1] = S0; sg_e[2] = S0; sg_e[3] = S0;
`endif
    do_load(16'h0000);
    scan_sync("scan0000");
    for (int k = 0; k < 4; k++) begin
      push(16'(an_e[k]));
      push(16'(sg_e[k]));
      check("s0_an", 16'(an));
      check("s0_seg", 16'(seg));
      repeat (2) @(negedge clk);
    end

    // Reset on a tick cycle with a wrap pending must win.
    do_load(16'h9999);
    en = 1'b1;
    while (mdiv != 2'd3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(16'h0000); check("mid_rst_count", count);
    push(16'h0000); check("mid_rst_carry", 16'(carry));
    push(16'h000F); check("mid_rst_an", 16'(an));
    push(16'h007F); check("mid_rst_seg", 16'(seg));
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    push(16'h000E); check("post_rst_an", 16'(an));
    push(16'(S0));  check("post_rst_seg", 16'(seg));
    push(16'h0000); check("post_rst_carry", 16'(carry));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
